// File: rtl/alu_wb_pkg.sv
// alu_wb_pkg: shared flag indices, widths and entry type for the ALU writeback stage
package alu_wb_pkg;
    localparam int WB_DATA_W  = 32;
    localparam int WB_FLAGS_W = 6;
    localparam int WB_TAG_W   = 7;
    localparam int WB_AL_ID_W = 7;
    localparam int FLG_WRDEST  = 4;
    localparam int FLG_EXEC    = 2;
    localparam int FLG_EXCEPT  = 1;
    localparam int FLG_MISPRED = 0;
    typedef struct packed {
        logic [WB_DATA_W-1:0]  result;
        logic [WB_FLAGS_W-1:0] flags;
        logic [WB_TAG_W-1:0]   tag;
        logic [WB_AL_ID_W-1:0] al_id;
    } wb_entry_t;
    function automatic logic writes_prf(input logic [WB_FLAGS_W-1:0] flags);
        return flags[FLG_WRDEST] & ~flags[FLG_EXCEPT];
    endfunction
endpackage

// File: rtl/alu_wb_stage_fifo.sv
// wb_skid_fifo: 2-entry FIFO of writeback entries with registered ready and flush
module wb_skid_fifo
    import alu_wb_pkg::*;
(
    input  logic      clk,
    input  logic      reset_n,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  wb_entry_t din,
    output wb_entry_t head,
    output logic      valid,
    output logic      ready
);
    wb_entry_t  mem [2];
    logic       wr_ptr, rd_ptr;
    logic [1:0] cnt, cnt_nxt;
    always_comb cnt_nxt = flush ? 2'd0 : cnt + {1'b0, push} - {1'b0, pop};
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
            ready  <= 1'b1;
        end else begin
            cnt   <= cnt_nxt;
            ready <= cnt_nxt != 2'd2;
            if (flush) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= din;
                    wr_ptr      <= ~wr_ptr;
                end
                if (pop) rd_ptr <= ~rd_ptr;
            end
        end
    end
    assign head  = mem[rd_ptr];
    assign valid = cnt != 2'd0;
endmodule

// File: rtl/alu_wb_stage.sv
// alu_wb_stage: queues ALU results and decodes them into PRF writes and completions
// Optional registered PRF bypass port set enabled by defining ALU_WB_BYPASS_EN.
module alu_wb_stage
    import alu_wb_pkg::*;
#(
    parameter int DATA_W  = WB_DATA_W,
    parameter int TAG_W   = WB_TAG_W,
    parameter int AL_ID_W = WB_AL_ID_W,
    parameter int FLAGS_W = WB_FLAGS_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [DATA_W-1:0]  result_i,
    input  logic [FLAGS_W-1:0] flags_i,
    input  logic [TAG_W-1:0]   tag_i,
    input  logic [AL_ID_W-1:0] al_id_i,
    input  logic               flush_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic               wr_en_o,
    output logic [TAG_W-1:0]   wr_tag_o,
    output logic [DATA_W-1:0]  wr_data_o,
    output logic [AL_ID_W-1:0] cmp_al_id_o,
    output logic [FLAGS_W-1:0] cmp_flags_o
`ifdef ALU_WB_BYPASS_EN
    ,
    output logic               bypass_valid_o,
    output logic [TAG_W-1:0]   bypass_tag_o,
    output logic [DATA_W-1:0]  bypass_data_o
`endif
);
    wb_entry_t din, head;
    logic      push, pop;
    assign push = valid_i & ready_o;
    assign pop  = out_valid_o & out_ready_i;
    assign din  = '{result: result_i, flags: flags_i, tag: tag_i, al_id: al_id_i};
    wb_skid_fifo u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (flush_i),
        .din     (din),
        .head    (head),
        .valid   (out_valid_o),
        .ready   (ready_o)
    );
    assign wr_en_o     = out_valid_o & writes_prf(head.flags);
    assign wr_tag_o    = head.tag;
    assign wr_data_o   = head.result;
    assign cmp_al_id_o = head.al_id;
    assign cmp_flags_o = head.flags;
`ifdef ALU_WB_BYPASS_EN
    // Captured at push time so forwarding never waits on downstream backpressure
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bypass_valid_o <= 1'b0;
            bypass_tag_o   <= '0;
            bypass_data_o  <= '0;
        end else begin
            bypass_valid_o <= push & writes_prf(flags_i) & ~flush_i;
            if (push) begin
                bypass_tag_o  <= tag_i;
                bypass_data_o <= result_i;
            end
        end
    end
`endif
endmodule

// File: tb/tb_alu_wb_stage.sv
// tb_alu_wb_stage: directed plus random checks of alu_wb_stage against a queue model
module tb_alu_wb_stage;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        valid_i = 1'b0, flush_i = 1'b0, out_ready_i = 1'b0;
    logic [31:0] result_i = '0;
    logic [5:0]  flags_i = '0;
    logic [6:0]  tag_i = '0, al_id_i = '0;
    logic        ready_o, out_valid_o, wr_en_o;
    logic [6:0]  wr_tag_o, cmp_al_id_o;
    logic [31:0] wr_data_o;
    logic [5:0]  cmp_flags_o;
`ifdef ALU_WB_BYPASS_EN
    logic        bypass_valid_o;
    logic [6:0]  bypass_tag_o;
    logic [31:0] bypass_data_o;
`endif
    typedef struct {
        logic [31:0] d;
        logic [5:0]  f;
        logic [6:0]  t;
        logic [6:0]  a;
    } ent_t;
    ent_t q[$];
    logic        exp_bv = 1'b0;
    logic [6:0]  exp_bt = '0;
    logic [31:0] exp_bd = '0;
    int checks = 0, errors = 0;

    alu_wb_stage dut (
        .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .ready_o(ready_o),
        .result_i(result_i), .flags_i(flags_i), .tag_i(tag_i), .al_id_i(al_id_i),
        .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .wr_en_o(wr_en_o), .wr_tag_o(wr_tag_o), .wr_data_o(wr_data_o),
        .cmp_al_id_o(cmp_al_id_o), .cmp_flags_o(cmp_flags_o)
`ifdef ALU_WB_BYPASS_EN
        , .bypass_valid_o(bypass_valid_o), .bypass_tag_o(bypass_tag_o),
        .bypass_data_o(bypass_data_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic nonempty;
        nonempty = q.size() > 0;
        chk("ready", 64'(ready_o), 64'(q.size() < 2));
        chk("out_valid", 64'(out_valid_o), 64'(nonempty));
        if (nonempty) begin
            chk("wr_en", 64'(wr_en_o), 64'(q[0].f[4] && !q[0].f[1]));
            chk("wr_data", 64'(wr_data_o), 64'(q[0].d));
            chk("wr_tag", 64'(wr_tag_o), 64'(q[0].t));
            chk("cmp_al_id", 64'(cmp_al_id_o), 64'(q[0].a));
            chk("cmp_flags", 64'(cmp_flags_o), 64'(q[0].f));
        end else chk("wr_en_idle", 64'(wr_en_o), 64'(0));
`ifdef ALU_WB_BYPASS_EN
        chk("bypass_valid", 64'(bypass_valid_o), 64'(exp_bv));
        if (exp_bv) begin
            chk("bypass_tag", 64'(bypass_tag_o), 64'(exp_bt));
            chk("bypass_data", 64'(bypass_data_o), 64'(exp_bd));
        end
`endif
    endtask

    // One clock: the model applies the stage rules to the inputs held across the edge
    task automatic cycle();
        logic p, o;
        ent_t e;
        p = valid_i && q.size() < 2;
        o = q.size() > 0 && out_ready_i;
        e = '{d: result_i, f: flags_i, t: tag_i, a: al_id_i};
        @(posedge clk);
        exp_bv = p && flags_i[4] && !flags_i[1] && !flush_i;
        if (p) begin
            exp_bt = tag_i;
            exp_bd = result_i;
        end
        if (flush_i) q.delete();
        else begin
            if (o) void'(q.pop_front());
            if (p) q.push_back(e);
        end
        #1 check_all();
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [5:0] f,
                         input logic [6:0] t, input logic [6:0] a);
        valid_i = v; result_i = d; flags_i = f; tag_i = t; al_id_i = a;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(out_valid_o), 64'(0));
        chk({tag, "_ready"}, 64'(ready_o), 64'(1));
        chk({tag, "_wr_en"}, 64'(wr_en_o), 64'(0));
        chk({tag, "_zero"}, 64'({wr_tag_o, wr_data_o, cmp_al_id_o, cmp_flags_o}), 64'(0));
`ifdef ALU_WB_BYPASS_EN
        chk({tag, "_byp"}, 64'({bypass_valid_o, bypass_tag_o, bypass_data_o}), 64'(0));
`endif
    endtask

    initial begin
        #12 chk_reset_outputs("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;
        // Single ADD
        out_ready_i = 1'b1;
        drive(1'b1, 32'h5, 6'b010100, 7'd3, 7'd9);
        cycle();
        chk("add_wr_en", 64'(wr_en_o), 64'(1));
        chk("add_data", 64'(wr_data_o), 64'(5));
        drive(1'b0, '0, '0, '0, '0);
        cycle();
        chk("add_drained", 64'(out_valid_o), 64'(0));
        // Backpressure
        out_ready_i = 1'b0;
        drive(1'b1, 32'hA, 6'b010100, 7'd10, 7'd1);
        cycle();
        drive(1'b1, 32'hB, 6'b010100, 7'd11, 7'd2);
        cycle();
        chk("bp_full_ready", 64'(ready_o), 64'(0));
        drive(1'b0, '0, '0, '0, '0);
        cycle();
        chk("bp_hold_tag", 64'(wr_tag_o), 64'(10));
        out_ready_i = 1'b1;
        cycle();
        chk("bp_ready_after_pop", 64'(ready_o), 64'(1));
        chk("bp_order", 64'(wr_tag_o), 64'(11));
        cycle();
        // Exception entry
        drive(1'b1, 32'h77, 6'b010110, 7'd4, 7'd5);
        cycle();
        chk("exc_wr_en", 64'(wr_en_o), 64'(0));
        chk("exc_flag", 64'(cmp_flags_o[1]), 64'(1));
        // NOP
        drive(1'b1, 32'h1, 6'b000100, 7'd6, 7'd7);
        cycle();
        chk("nop_wr_en", 64'(wr_en_o), 64'(0));
        drive(1'b0, '0, '0, '0, '0);
        cycle();
        // Flush at count=2 with a concurrent push
        out_ready_i = 1'b0;
        drive(1'b1, 32'h21, 6'b010100, 7'd21, 7'd21);
        cycle();
        drive(1'b1, 32'h22, 6'b010100, 7'd22, 7'd22);
        cycle();
        drive(1'b1, 32'h23, 6'b010100, 7'd23, 7'd23);
        flush_i = 1'b1;
        out_ready_i = 1'b1;
        cycle();
        chk("flush_valid", 64'(out_valid_o), 64'(0));
        chk("flush_ready", 64'(ready_o), 64'(1));
        flush_i = 1'b0;
        drive(1'b0, '0, '0, '0, '0);
        cycle();
        chk("flush_no_ghost", 64'(out_valid_o), 64'(0));
`ifdef ALU_WB_BYPASS_EN
        // Bypass under backpressure
        out_ready_i = 1'b0;
        drive(1'b1, 32'hDEAD_BEEF, 6'b010100, 7'd5, 7'd1);
        cycle();
        chk("byp_valid", 64'(bypass_valid_o), 64'(1));
        chk("byp_tag", 64'(bypass_tag_o), 64'(5));
        chk("byp_data", 64'(bypass_data_o), 64'hDEAD_BEEF);
        chk("byp_queued", 64'(out_valid_o), 64'(1));
        drive(1'b0, '0, '0, '0, '0);
        out_ready_i = 1'b1;
        cycle();
`endif
        // Async reset with two entries, asserted away from any clock edge
        out_ready_i = 1'b0;
        drive(1'b1, 32'h31, 6'b010100, 7'd31, 7'd31);
        cycle();
        drive(1'b1, 32'h32, 6'b010100, 7'd32, 7'd32);
        cycle();
        drive(1'b0, '0, '0, '0, '0);
        #2 reset_n = 1'b0;
        #1 chk_reset_outputs("async_reset");
        q.delete();
        exp_bv = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        out_ready_i = 1'b1;
        drive(1'b1, 32'h5, 6'b010100, 7'd3, 7'd9);
        cycle();
        chk("post_reset_wr_en", 64'(wr_en_o), 64'(1));
        chk("post_reset_tag", 64'(wr_tag_o), 64'(3));
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom), $urandom, 6'($urandom), 7'($urandom), 7'($urandom));
            out_ready_i = 1'($urandom_range(0, 2) != 0);
            flush_i = $urandom_range(0, 15) == 0;
            cycle();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
